traffic_request_scheduler: RTL and testbench

Front-end scheduler for the intersection light controller core. It latches pedestrian-button and car-detector requests and counts queued cars. It arbitrates between pedestrian and car service (alternating on ties), gives emergency requests preemptive priority, and drives the core's request inputs (sensor_pedestrian, sensor_car, emergency) plus an adaptive time_slot. It watches the core's light outputs to confirm when service starts and ends.

---
 rtl/traffic_request_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_traffic_request_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_request_scheduler.sv
// traffic_request_scheduler: latches pedestrian/car requests, arbitrates service and drives the light controller core
module traffic_request_scheduler #(
    parameter int N_PED        = 4,
    parameter int BASE_SLOT    = 4,
    parameter int MAX_SLOT     = 15,
    parameter int WAIT_TIMEOUT = 63,
    parameter int EMG_HOLD     = 8,
    parameter int COOL_CYCLES  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_PED-1:0] ped_btn,
    input  logic             car_det_ns,
    input  logic             car_det_ew,
    input  logic             emg_req,
    input  logic [2:0]       light_NS,
    input  logic [2:0]       light_EW,
    input  logic             ped_walk,
    output logic [3:0]       time_slot,
    output logic             sensor_car,
    output logic             sensor_pedestrian,
    output logic             emergency,
    output logic [N_PED-1:0] ped_pending,
    output logic [3:0]       car_count,
    output logic             timeout_err
);
    localparam int HW = $clog2(EMG_HOLD + 1);
    localparam int CW = (COOL_CYCLES > 1) ? $clog2(COOL_CYCLES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SERVE, S_COOL, S_EMG} state_t;

    state_t           state_q, state_d;
    logic             grant_ped_q, grant_ped_d;
    logic             last_ped_q, last_ped_d;
    logic [5:0]       wait_q, wait_d;
    logic [CW-1:0]    cool_q, cool_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [3:0]       time_slot_q, time_slot_d;
    logic             sensor_car_q, sensor_car_d;
    logic             sensor_ped_q, sensor_ped_d;
    logic             emergency_q, emergency_d;
    logic             timeout_q, timeout_d;
    logic [N_PED-1:0] ped_q, ped_d;
    logic [3:0]       cars_q, cars_d;
    logic             ns_q, ew_q;
    logic             clr_ped, clr_car, start, done;
    logic [5:0]       ped_cnt, ped_slot, car_slot;
    logic [4:0]       car_sum;

    // Request bookkeeping: sticky button bits and saturating car queue; a same-cycle set/edge beats the clear
    always_comb begin
        ped_cnt = '0;
        for (int i = 0; i < N_PED; i++) ped_cnt = ped_cnt + {5'd0, ped_q[i]};
        ped_slot = 6'(BASE_SLOT) + ped_cnt;
        car_slot = 6'(BASE_SLOT) + {2'b00, cars_q};
        ped_d    = (ped_q & ~{N_PED{clr_ped}}) | ped_btn;
        car_sum  = (clr_car ? 5'd0 : {1'b0, cars_q}) + {4'd0, car_det_ns & ~ns_q} + {4'd0, car_det_ew & ~ew_q};
        cars_d   = (car_sum > 5'd15) ? 4'd15 : car_sum[3:0];
    end

    // Arbitration FSM: next state, registered request outputs and grant bookkeeping
    always_comb begin
        state_d      = state_q;
        grant_ped_d  = grant_ped_q;
        last_ped_d   = last_ped_q;
        wait_d       = wait_q;
        cool_d       = cool_q;
        hold_d       = hold_q;
        time_slot_d  = time_slot_q;
        sensor_car_d = 1'b0;
        sensor_ped_d = 1'b0;
        emergency_d  = 1'b0;
        timeout_d    = 1'b0;
        clr_ped      = 1'b0;
        clr_car      = 1'b0;
        start        = grant_ped_q ? ped_walk : (light_NS == 3'b001);
        done         = grant_ped_q ? !ped_walk : (light_NS == 3'b100 && light_EW == 3'b100);
        if (emg_req && state_q != S_EMG) begin
            state_d     = S_EMG;
            emergency_d = 1'b1;
            hold_d      = HW'(EMG_HOLD);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|ped_q || |cars_q) begin
                        grant_ped_d  = |ped_q && (cars_q == 4'd0 || !last_ped_q);
                        time_slot_d  = grant_ped_d
                            ? ((ped_slot > 6'(MAX_SLOT)) ? 4'(MAX_SLOT) : ped_slot[3:0])
                            : ((car_slot > 6'(MAX_SLOT)) ? 4'(MAX_SLOT) : car_slot[3:0]);
                        sensor_ped_d = grant_ped_d;
                        sensor_car_d = !grant_ped_d;
                        wait_d       = '0;
                        state_d      = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (start) begin
                        clr_ped    = grant_ped_q;
                        clr_car    = !grant_ped_q;
                        last_ped_d = grant_ped_q;
                        state_d    = S_SERVE;
                    end else if (wait_q == 6'(WAIT_TIMEOUT - 1)) begin
                        timeout_d = 1'b1;
                        cool_d    = '0;
                        state_d   = S_COOL;
                    end else begin
                        wait_d       = wait_q + 6'd1;
                        sensor_ped_d = grant_ped_q;
                        sensor_car_d = !grant_ped_q;
                    end
                end
                S_SERVE: begin
                    if (done) begin
                        cool_d  = '0;
                        state_d = S_COOL;
                    end
                end
                S_COOL: begin
                    cool_d  = cool_q + CW'(1);
                    state_d = (cool_q == CW'(COOL_CYCLES - 1)) ? S_IDLE : S_COOL;
                end
                S_EMG: begin
                    emergency_d = 1'b1;
                    if (emg_req) begin
                        hold_d = HW'(EMG_HOLD);
                    end else if (hold_q == HW'(1)) begin
                        emergency_d = 1'b0;
                        cool_d      = '0;
                        state_d     = S_COOL;
                    end else begin
                        hold_d = hold_q - HW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers; first tie after reset goes to pedestrians (last served = car)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            grant_ped_q  <= 1'b0;
            last_ped_q   <= 1'b0;
            wait_q       <= '0;
            cool_q       <= '0;
            hold_q       <= '0;
            time_slot_q  <= 4'(BASE_SLOT);
            sensor_car_q <= 1'b0;
            sensor_ped_q <= 1'b0;
            emergency_q  <= 1'b0;
            timeout_q    <= 1'b0;
            ped_q        <= '0;
            cars_q       <= '0;
            ns_q         <= 1'b0;
            ew_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_ped_q  <= grant_ped_d;
            last_ped_q   <= last_ped_d;
            wait_q       <= wait_d;
            cool_q       <= cool_d;
            hold_q       <= hold_d;
            time_slot_q  <= time_slot_d;
            sensor_car_q <= sensor_car_d;
            sensor_ped_q <= sensor_ped_d;
            emergency_q  <= emergency_d;
            timeout_q    <= timeout_d;
            ped_q        <= ped_d;
            cars_q       <= cars_d;
            ns_q         <= car_det_ns;
            ew_q         <= car_det_ew;
        end
    end

    assign time_slot         = time_slot_q;
    assign sensor_car        = sensor_car_q;
    assign sensor_pedestrian = sensor_ped_q;
    assign emergency         = emergency_q;
    assign timeout_err       = timeout_q;
    assign ped_pending       = ped_q;
    assign car_count         = cars_q;
endmodule

// File: tb/tb_traffic_request_scheduler.sv
// tb_traffic_request_scheduler: directed scenarios plus randomized traffic against a behavioural model
module tb_traffic_request_scheduler;
    localparam int N_PED = 4, BASE_SLOT = 4, MAX_SLOT = 15, WAIT_TIMEOUT = 63, EMG_HOLD = 8, COOL_CYCLES = 2;
    localparam int P_IDLE = 0, P_WAIT = 1, P_SERVE = 2, P_COOL = 3, P_EMG = 4;

    logic       clk, rst_n, car_det_ns, car_det_ew, emg_req, ped_walk;
    logic [3:0] ped_btn;
    logic [2:0] light_NS, light_EW;
    logic [3:0] time_slot, car_count, ped_pending;
    logic       sensor_car, sensor_pedestrian, emergency, timeout_err;

    int total = 0, bad = 0;
    int m_phase, m_left, m_ped, m_cars, e_ts, n;
    bit m_ped_grant, m_last_ped, e_sc, e_sp, e_emg, e_to, p_ns, p_ew;
    int walk_left, green_left, car_phase;

    traffic_request_scheduler #(
        .N_PED(N_PED), .BASE_SLOT(BASE_SLOT), .MAX_SLOT(MAX_SLOT),
        .WAIT_TIMEOUT(WAIT_TIMEOUT), .EMG_HOLD(EMG_HOLD), .COOL_CYCLES(COOL_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ped_btn(ped_btn), .car_det_ns(car_det_ns), .car_det_ew(car_det_ew),
        .emg_req(emg_req), .light_NS(light_NS), .light_EW(light_EW), .ped_walk(ped_walk),
        .time_slot(time_slot), .sensor_car(sensor_car), .sensor_pedestrian(sensor_pedestrian),
        .emergency(emergency), .ped_pending(ped_pending), .car_count(car_count), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sat(input int v);
        return (v > MAX_SLOT) ? MAX_SLOT : v;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_left = 0; m_ped = 0; m_cars = 0; m_ped_grant = 0; m_last_ped = 0;
        e_ts = BASE_SLOT; e_sc = 0; e_sp = 0; e_emg = 0; e_to = 0; p_ns = 0; p_ew = 0;
    endtask

    // One clock of the service rules: emergency first, then the current phase, then request bookkeeping
    task automatic model_step();
        int rises, np, nc;
        rises = int'(car_det_ns && !p_ns) + int'(car_det_ew && !p_ew);
        np = m_ped; nc = m_cars;
        e_sc = 0; e_sp = 0; e_to = 0; e_emg = 0;
        if (emg_req && m_phase != P_EMG) begin
            m_phase = P_EMG; m_left = EMG_HOLD; e_emg = 1;
        end else if (m_phase == P_IDLE) begin
            if (m_ped != 0 || m_cars != 0) begin
                m_ped_grant = (m_ped != 0) && (m_cars == 0 || !m_last_ped);
                e_ts = m_ped_grant ? sat(BASE_SLOT + $countones(m_ped)) : sat(BASE_SLOT + m_cars);
                e_sp = m_ped_grant; e_sc = !m_ped_grant;
                m_phase = P_WAIT; m_left = WAIT_TIMEOUT;
            end
        end else if (m_phase == P_WAIT) begin
            if (m_ped_grant ? ped_walk : (light_NS == 3'b001)) begin
                if (m_ped_grant) np = 0; else nc = 0;
                m_last_ped = m_ped_grant; m_phase = P_SERVE;
            end else begin
                m_left--;
                if (m_left == 0) begin e_to = 1; m_phase = P_COOL; m_left = COOL_CYCLES; end
                else begin e_sp = m_ped_grant; e_sc = !m_ped_grant; end
            end
        end else if (m_phase == P_SERVE) begin
            if (m_ped_grant ? !ped_walk : (light_NS == 3'b100 && light_EW == 3'b100)) begin
                m_phase = P_COOL; m_left = COOL_CYCLES;
            end
        end else if (m_phase == P_COOL) begin
            m_left--;
            if (m_left == 0) m_phase = P_IDLE;
        end else begin
            e_emg = 1;
            if (emg_req) m_left = EMG_HOLD;
            else begin
                m_left--;
                if (m_left == 0) begin e_emg = 0; m_phase = P_COOL; m_left = COOL_CYCLES; end
            end
        end
        m_ped  = np | int'(ped_btn);
        m_cars = (nc + rises > 15) ? 15 : nc + rises;
        p_ns = car_det_ns; p_ew = car_det_ew;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset(); else model_step();
        #1;
        chk("time_slot", int'(time_slot), e_ts);
        chk("sensor_car", int'(sensor_car), int'(e_sc));
        chk("sensor_pedestrian", int'(sensor_pedestrian), int'(e_sp));
        chk("emergency", int'(emergency), int'(e_emg));
        chk("timeout_err", int'(timeout_err), int'(e_to));
        chk("ped_pending", int'(ped_pending), m_ped);
        chk("car_count", int'(car_count), m_cars);
    endtask

    // Randomized traffic plus a core that answers requests after a random delay
    task automatic random_cycle();
        if (walk_left > 0) begin
            walk_left--;
            if (walk_left == 0) ped_walk = 1'b0;
        end else if (sensor_pedestrian && $urandom_range(0, 2) == 0) begin
            ped_walk = 1'b1; walk_left = $urandom_range(1, 4);
        end
        if (car_phase == 1) begin
            green_left--;
            if (green_left == 0) begin light_NS = 3'b010; car_phase = 2; end
        end else if (car_phase == 2) begin
            light_NS = 3'b100; car_phase = 0;
        end else if (sensor_car && $urandom_range(0, 2) == 0) begin
            light_NS = 3'b001; green_left = $urandom_range(1, 4); car_phase = 1;
        end
        emg_req    = emg_req ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 149) == 0);
        ped_btn    = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'b0000;
        car_det_ns = ($urandom_range(0, 5) == 0) ? !car_det_ns : car_det_ns;
        car_det_ew = ($urandom_range(0, 6) == 0) ? !car_det_ew : car_det_ew;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; ped_btn = '0; car_det_ns = 0; car_det_ew = 0; emg_req = 0; ped_walk = 0;
        light_NS = 3'b100; light_EW = 3'b100;
        walk_left = 0; green_left = 0; car_phase = 0;
        model_reset();
        tick(); tick();
        chk("reset_time_slot", int'(time_slot), BASE_SLOT);
        rst_n = 1'b1;
        tick();

        // pedestrian grant with two buttons
        ped_btn = 4'b0101; tick();
        ped_btn = 4'b0000; tick();
        chk("ped_grant_req", int'(sensor_pedestrian), 1);
        chk("ped_grant_slot", int'(time_slot), 6);
        tick();
        ped_walk = 1'b1; tick();
        chk("ped_start_drop", int'(sensor_pedestrian), 0);
        chk("ped_start_clear", int'(ped_pending), 0);
        ped_walk = 1'b0; tick(); tick(); tick(); tick();

        // asynchronous reset in the middle of a car wait
        car_det_ns = 1'b1; tick();
        car_det_ns = 1'b0; tick();
        chk("car_wait_req", int'(sensor_car), 1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_car", int'(sensor_car), 0);
        chk("async_rst_slot", int'(time_slot), BASE_SLOT);
        chk("async_rst_count", int'(car_count), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_count", int'(car_count), 0);

        // tie after reset: pedestrian first, then cars with the accumulated queue
        car_det_ns = 1'b1; ped_btn = 4'b0001; tick();
        car_det_ns = 1'b0; ped_btn = 4'b0000; tick();
        chk("tie_ped_first", int'(sensor_pedestrian), 1);
        car_det_ns = 1'b1; tick();
        car_det_ns = 1'b0; tick();
        car_det_ns = 1'b1; tick();
        car_det_ns = 1'b0; ped_walk = 1'b1; tick();
        ped_walk = 1'b0;
        for (int k = 0; k < 10 && sensor_car !== 1'b1; k++) tick();
        chk("tie_car_second", int'(sensor_car), 1);
        chk("tie_car_slot", int'(time_slot), 7);
        light_NS = 3'b001; tick();
        chk("car_start_clear", int'(car_count), 0);
        light_NS = 3'b010; tick();
        light_NS = 3'b100; tick();

        // saturation: 20 edges queued under emergency, one cycle with both detectors rising
        emg_req = 1'b1; tick();
        for (int i = 0; i < 19; i++) begin
            car_det_ns = 1'b1; car_det_ew = (i == 5); tick();
            car_det_ns = 1'b0; car_det_ew = 1'b0; tick();
        end
        chk("sat_count", int'(car_count), 15);
        emg_req = 1'b0;
        for (int k = 0; k < 30 && sensor_car !== 1'b1; k++) tick();
        chk("sat_regrant", int'(sensor_car), 1);
        chk("sat_slot", int'(time_slot), 15);
        light_NS = 3'b001; tick();
        light_NS = 3'b010; tick();
        light_NS = 3'b100; tick(); tick(); tick();

        // emergency preempts a car wait, hold, then the car is granted again
        car_det_ns = 1'b1; tick();
        car_det_ns = 1'b0;
        for (int k = 0; k < 10 && sensor_car !== 1'b1; k++) tick();
        chk("emg_pre_req", int'(sensor_car), 1);
        emg_req = 1'b1; tick();
        chk("emg_drop_car", int'(sensor_car), 0);
        chk("emg_assert", int'(emergency), 1);
        chk("emg_keep_count", int'(car_count), 1);
        emg_req = 1'b0;
        for (int k = 0; k < EMG_HOLD - 1; k++) begin
            tick();
            chk("emg_hold", int'(emergency), 1);
        end
        tick();
        chk("emg_release", int'(emergency), 0);
        for (int k = 0; k < 10 && sensor_car !== 1'b1; k++) tick();
        chk("emg_regrant", int'(sensor_car), 1);
        chk("emg_regrant_slot", int'(time_slot), 5);
        light_NS = 3'b001; tick();
        light_NS = 3'b010; tick();
        light_NS = 3'b100; tick();

        // timeout: the core never starts pedestrian service
        ped_btn = 4'b1000; tick();
        ped_btn = 4'b0000;
        for (int k = 0; k < 10 && sensor_pedestrian !== 1'b1; k++) tick();
        n = 0;
        while (sensor_pedestrian === 1'b1 && n < 100) begin n++; tick(); end
        chk("timeout_wait_len", n, WAIT_TIMEOUT);
        chk("timeout_pulse", int'(timeout_err), 1);
        chk("timeout_keep_ped", int'(ped_pending), 8);
        tick();
        chk("timeout_one_cycle", int'(timeout_err), 0);
        for (int k = 0; k < 10 && sensor_pedestrian !== 1'b1; k++) tick();
        chk("timeout_regrant", int'(sensor_pedestrian), 1);
        ped_walk = 1'b1; tick();
        ped_walk = 1'b0; tick();

        for (int i = 0; i < 2000; i++) random_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
